// File: rtl/ram_pattern_tester.sv
// ram_pattern_tester
// Self-test sequencer for a single-port synchronous RAM with one-cycle read
// latency. On an accepted start it writes an address-derived pattern to
// every entry, reads everything back and compares, then repeats the fill and
// check with the inverted pattern. While busy is high this block owns the
// RAM port.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   start            : begin a test (accepted only when idle or done)
//   busy             : test in progress
//   done             : test finished, held until the next accepted start
//   pass             : valid while done; 1 when no mismatch was seen
//   error_count      : mismatched words, saturating
//   fail_valid       : at least one mismatch recorded this test
//   first_fail_addr  : address of the first mismatch
//   ram_address, ram_write_data, ram_write_en : RAM request side
//   ram_read_data    : RAM data for the address of the previous cycle
module ram_pattern_tester #(
    parameter int              SIZE  = 8,
    parameter int              DEPTH = 256,
    parameter logic [SIZE-1:0] SEED  = 8'hA5,
    parameter int              ERR_W = 16,
    localparam int             AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] error_count,
    output logic             fail_valid,
    output logic [AW-1:0]    first_fail_addr,
    output logic [AW-1:0]    ram_address,
    output logic [SIZE-1:0]  ram_write_data,
    output logic             ram_write_en,
    input  logic [SIZE-1:0]  ram_read_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              phase_q, phase_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [SIZE-1:0]   wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              fv_q, fv_d;
    logic [AW-1:0]     ffa_q, ffa_d;
    logic              cmp_valid_q, cmp_valid_d;
    logic [AW-1:0]     cmp_addr_q, cmp_addr_d;
    logic [SIZE-1:0]   cmp_exp_q, cmp_exp_d;

    logic              last_addr;
    logic              accept;
    logic              mismatch;

    function automatic logic [SIZE-1:0] pattern(input logic [AW-1:0] a, input logic inv);
        logic [SIZE-1:0] p;
        p = SIZE'(a) + SEED;
        return inv ? ~p : p;
    endfunction

    assign last_addr = (addr_q == AW'(DEPTH - 1));
    assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);
    // Read data in this cycle belongs to the address issued last cycle.
    assign mismatch  = cmp_valid_q && (ram_read_data != cmp_exp_q);

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fv_q        <= 1'b0;
            ffa_q       <= '0;
            cmp_valid_q <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_exp_q   <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            fv_q        <= fv_d;
            ffa_q       <= ffa_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_exp_q   <= cmp_exp_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_WRITE;
            S_WRITE: if (last_addr) state_d = S_READ;
            S_READ:  if (last_addr) state_d = S_DRAIN;
            S_DRAIN: state_d = phase_q ? S_DONE : S_WRITE;
            S_DONE:  if (start) state_d = S_WRITE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        phase_d     = phase_q;
        if (accept)
            phase_d = 1'b0;
        else if (state_q == S_DRAIN)
            phase_d = 1'b1;

        // Address restarts at 0 on every phase change, so it never runs past DEPTH-1.
        if (state_d != state_q)
            addr_d = '0;
        else if (state_q == S_WRITE || state_q == S_READ)
            addr_d = addr_q + AW'(1);
        else
            addr_d = addr_q;

        we_d        = (state_d == S_WRITE);
        wdata_d     = (state_d == S_WRITE) ? pattern(addr_d, phase_d) : wdata_q;
        busy_d      = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
        done_d      = (state_d == S_DONE);

        cmp_valid_d = (state_q == S_READ);
        cmp_addr_d  = addr_q;
        cmp_exp_d   = pattern(addr_q, phase_q);

        err_d       = err_q;
        fv_d        = fv_q;
        ffa_d       = ffa_q;
        pass_d      = pass_q;
        if (accept) begin
            err_d  = '0;
            fv_d   = 1'b0;
            ffa_d  = '0;
            pass_d = 1'b0;
        end else begin
            if (mismatch) begin
                if (err_q != {ERR_W{1'b1}})
                    err_d = err_q + ERR_W'(1);
                if (!fv_q) begin
                    fv_d  = 1'b1;
                    ffa_d = cmp_addr_q;
                end
            end
            // The final compare lands in the pass-1 drain cycle, so use err_d.
            if (state_q == S_DRAIN && phase_q)
                pass_d = (err_d == '0);
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign error_count     = err_q;
    assign fail_valid      = fv_q;
    assign first_fail_addr = ffa_q;
    assign ram_address     = addr_q;
    assign ram_write_data  = wdata_q;
    assign ram_write_en    = we_q;

endmodule

// File: tb/tb_ram_pattern_tester.sv
module tb_ram_pattern_tester;

    localparam int DEPTH = 16;
    localparam int SIZE  = 8;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    // main DUT (ERR_W=16)
    logic            busy, done, pass, fail_valid, ram_write_en;
    logic [15:0]     error_count;
    logic [AW-1:0]   first_fail_addr, ram_address;
    logic [SIZE-1:0] ram_write_data, ram_read_data;

    // saturation DUT (ERR_W=2), RAM inverts every read
    logic            s_busy, s_done, s_pass, s_fail_valid, s_we;
    logic [1:0]      s_err;
    logic [AW-1:0]   s_ffa, s_addr;
    logic [SIZE-1:0] s_wdata, s_rdata;

    ram_pattern_tester #(.SIZE(SIZE), .DEPTH(DEPTH), .SEED(8'hA5), .ERR_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .error_count(error_count), .fail_valid(fail_valid), .first_fail_addr(first_fail_addr),
        .ram_address(ram_address), .ram_write_data(ram_write_data),
        .ram_write_en(ram_write_en), .ram_read_data(ram_read_data));

    ram_pattern_tester #(.SIZE(SIZE), .DEPTH(DEPTH), .SEED(8'hA5), .ERR_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(start), .busy(s_busy), .done(s_done), .pass(s_pass),
        .error_count(s_err), .fail_valid(s_fail_valid), .first_fail_addr(s_ffa),
        .ram_address(s_addr), .ram_write_data(s_wdata),
        .ram_write_en(s_we), .ram_read_data(s_rdata));

    // RAM models. fault_mode: 0 ideal, 1 addr 5 bit 0 stuck at 1, 2 writes to 3 and 9 dropped
    int         fault_mode = 0;
    logic       ram_clr = 1'b0;
    logic [7:0] mem  [DEPTH];
    logic [7:0] smem [DEPTH];

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else if (ram_write_en && !(fault_mode == 2 && (ram_address == 4'd3 || ram_address == 4'd9)))
            mem[ram_address] <= ram_write_data;
        ram_read_data <= mem[ram_address] | ((fault_mode == 1 && ram_address == 4'd5) ? 8'h01 : 8'h00);
    end

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < DEPTH; i++) smem[i] <= 8'h00;
        end else if (s_we)
            smem[s_addr] <= s_wdata;
        s_rdata <= ~smem[s_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int a, input int p);
        logic [7:0] v;
        v = 8'(a) + 8'hA5;
        return (p != 0) ? ~v : v;
    endfunction

    // Reference behaviour of a full test against a RAM with the given fault.
    function automatic void model(input int fault, input int emax, output int err, output int ffa);
        logic [7:0] m [DEPTH];
        logic [7:0] rd;
        for (int a = 0; a < DEPTH; a++) m[a] = 8'h00;
        err = 0;
        ffa = -1;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < DEPTH; a++)
                if (!(fault == 2 && (a == 3 || a == 9))) m[a] = pat(a, p);
            for (int a = 0; a < DEPTH; a++) begin
                rd = m[a];
                if (fault == 1 && a == 5) rd[0] = 1'b1;
                if (fault == 3) rd = ~rd;
                if (rd != pat(a, p)) begin
                    if (err < emax) err++;
                    if (ffa < 0) ffa = a;
                end
            end
        end
        if (ffa < 0) ffa = 0;
    endfunction

    typedef struct { int addr; logic [7:0] data; } wr_t;
    typedef struct { int cycles; int err; int ffa; } res_t;
    wr_t  wr_q[$];
    res_t res_q[$];
    logic mon_en = 1'b0;

    // Write-stream scoreboard
    always @(negedge clk) begin
        if (mon_en && ram_write_en) begin
            wr_t w;
            check("we_busy", busy, 1);
            if (wr_q.size() == 0)
                check("wr_extra", ram_address, 32'hFFFF_FFFF);
            else begin
                w = wr_q.pop_front();
                check("wr_addr", ram_address, w.addr);
                check("wr_data", ram_write_data, w.data);
            end
        end
    end

    task automatic clear_ram();
        @(posedge clk); #1 ram_clr = 1'b1;
        @(posedge clk); #1 ram_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_test(input string name, input int fault, input int mid_start);
        int   e, f, se, sf, cyc, guard;
        res_t r;
        fault_mode = fault;
        clear_ram();
        model(fault, 65535, e, f);
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < DEPTH; a++) wr_q.push_back('{a, pat(a, p)});
        res_q.push_back('{4 * DEPTH + 2, e, f});
        mon_en = 1'b1;
        pulse_start();
        // first cycle after the accepted start
        check({name, "_busy0"}, busy, 1);
        check({name, "_done_clr"}, done, 0);
        check({name, "_err_clr"}, error_count, 0);
        check({name, "_fv_clr"}, fail_valid, 0);
        cyc = 0;
        guard = 0;
        while (!done && guard < 400) begin
            if (busy) cyc++;
            if (mid_start != 0 && guard == 20) start = 1'b1;
            else if (mid_start != 0 && guard == 21) start = 1'b0;
            guard++;
            @(negedge clk);
        end
        mon_en = 1'b0;
        r = res_q.pop_front();
        check({name, "_done"}, done, 1);
        check({name, "_busy_end"}, busy, 0);
        check({name, "_cycles"}, cyc, r.cycles);
        check({name, "_err"}, error_count, r.err);
        check({name, "_pass"}, pass, (r.err == 0) ? 1 : 0);
        check({name, "_fv"}, fail_valid, (r.err != 0) ? 1 : 0);
        check({name, "_ffa"}, first_fail_addr, r.ffa);
        check({name, "_wr_left"}, wr_q.size(), 0);
        model(3, 3, se, sf);
        check({name, "_sat_done"}, s_done, 1);
        check({name, "_sat_err"}, s_err, se);
        check({name, "_sat_ffa"}, s_ffa, sf);
        check({name, "_sat_pass"}, s_pass, 0);
        wr_q.delete();
        @(negedge clk);
        check({name, "_done_hold"}, done, 1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_fv", fail_valid, 0);
        check("rst_we", ram_write_en, 0);
        check("rst_err", error_count, 0);
        check("rst_ffa", first_fail_addr, 0);
        check("rst_addr", ram_address, 0);
        check("rst_wdata", ram_write_data, 0);
        #1 rst = 1'b0;

        run_test("ideal", 0, 0);
        run_test("stuck", 1, 0);
        run_test("drop", 2, 1);
        run_test("restart", 0, 0);

        // reset during pass-0 READ
        fault_mode = 0;
        clear_ram();
        pulse_start();
        repeat (DEPTH + 3) @(negedge clk);
        check("abort_in_read_we", ram_write_en, 0);
        check("abort_in_read_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_we", ram_write_en, 0);
        check("abort_done", done, 0);
        check("abort_addr", ram_address, 0);
        check("abort_sat_busy", s_busy, 0);
        run_test("after_rst", 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
